dbus_sram_resp: RTL and testbench
=================================

// Module: dbus_sram_resp
// PURPOSE
//  Responder end of the core data bus (dbus_en/we/size/addr/data from the MEM stage).
//  - Checks alignment, builds SRAM byte strobes and lane-replicated write data.
//  - Drives a single-port synchronous SRAM with a fixed read latency.
//  - Stalls the pipeline until the access completes, then returns the right-aligned read word.
//  - Sits between the MEM-stage memctl and the data SRAM / cache port.
// PARAMETERS
//  LATENCY  1  SRAM read latency in cycles, from sram_en to sram_rdata valid; legal 1..7
// PORTS
//  clk         in   1   single clock, all flops rising edge
//  rst_n       in   1   asynchronous, active-low reset
//  dbus_en     in   1   request valid; the core holds the request stable while dbus_stall=1
//  dbus_we     in   1   1=store, 0=load
//  dbus_size   in   2   0=byte, 1=half, 2=word, 3=illegal
//  dbus_addr   in   32  byte address
//  dbus_data   in   32  store data, right-aligned
//  dbus_stall  out  1   pipeline hold
//  dbus_rdata  out  32  load data, right-aligned, zero-extended (the core sign-extends)
//  dbus_adel   out  1   load address error (feeds bus_error load field)
//  dbus_ades   out  1   store address error (feeds bus_error store field)
//  sram_en     out  1   SRAM access strobe, one cycle per access
//  sram_wen    out  4   SRAM byte write enables, bit i = byte lane i
//  sram_addr   out  32  SRAM word address: {dbus_addr[31:2],2'b00}
//  sram_wdata  out  32  SRAM write data
//  sram_rdata  in   32  SRAM read data, valid LATENCY cycles after sram_en
// BEHAVIOUR
//  - Reset: state=IDLE, counter=0; all outputs 0 (sram_* registered, so also low during reset).
//  - Misaligned access: half with addr[0]=1; word with addr[1:0]!=0; any size==3.
//    - In IDLE, combinational: adel = en & ~we & mis; ades = en & we & mis.
//    - stall=0 in that cycle; no SRAM access; state stays IDLE.
//  - Accept: in IDLE (cycle N) with en & ~mis:
//    - stall=1 combinationally in cycle N.
//    - we, size, addr[1:0], wen and wdata are latched.
//  - FSM states: IDLE, ISSUE, WAIT, DONE.
//    - IDLE -> ISSUE on accept.
//    - ISSUE (N+1): sram_en=1 with latched addr, wen and wdata. Loads go to WAIT with cnt=LATENCY-1; stores go to DONE.
//    - WAIT: capture sram_rdata when cnt==0, then go to DONE; otherwise cnt-=1.
//    - DONE: stall=0; dbus_rdata valid (loads); next state IDLE.
//  - Latency:
//    - Load: stall high cycles N..N+1+LATENCY, low at N+2+LATENCY.
//    - Store: stall high N..N+1, low at N+2.
//  - stall=1 in ISSUE and WAIT; stall=0 in IDLE and DONE.
//  - Requests arriving in DONE are ignored (the pipeline advances on that edge). Back-to-back throughput: 1 access per (3+LATENCY) cycles for loads, 3 cycles for stores.
//  - Write lanes, o=addr[1:0]:
//    - byte: wen=1<<o, wdata={4{data[7:0]}}
//    - half: wen=o[1]?4'b1100:4'b0011, wdata={2{data[15:0]}}
//    - word: wen=4'b1111, wdata=data
//    - loads: wen=0
//  - Read alignment: rdata = raw >> (8*o), then masked to 8/16/32 bits by size (upper bits 0).
//  - dbus_rdata is registered and holds its value until the next load completes.
//  - Input changes while busy (ISSUE/WAIT) are ignored; the latched request is used.
//  - Reset mid-operation: immediate return to IDLE, sram_en dropped, no completion is reported.
// STRUCTURE
//  - Shared package `includes` gains:
//    - dbus size constants SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd2
//    - typedef enum logic [1:0] dresp_state_t {DR_IDLE, DR_ISSUE, DR_WAIT, DR_DONE}
//  - One combinational sub-module, dbus_lane (inputs size, offset, data; outputs mis, wen, wdata).
//    - It is reused later by the cache refill path.
//  - FSM, counter and read alignment live in this module.
// TESTING
//  - Word load, LATENCY=1, addr 0x100, sram_rdata=0xDEADBEEF -> stall high 3 cycles; rdata=0xDEADBEEF at N+3; one sram_en pulse.
//  - Byte store data 0x000000A5 at addr 0x203 -> sram_wen=4'b1000, sram_wdata=0xA5A5A5A5, sram_addr=0x200; stall low at N+2.
//  - Half load at 0x102, SRAM word 0x12345678 -> rdata=0x00001234.
//  - Word store at 0x101 -> ades=1 in cycle N, stall=0, sram_en never asserted; half load at 0x103 -> adel=1.
//  - LATENCY=4, two back-to-back word loads -> second accepted at the first's DONE+1; each stall window is 6 cycles.
//  - rst_n low during WAIT -> next edge: sram_en=0, stall=0, rdata=0; the following load completes normally.

Source files
------------

// File: rtl/dbus_sram_resp_pkg.sv
// Shared data-bus definitions: size codes, responder FSM states, latched request.
package dbus_sram_resp_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {DR_IDLE, DR_ISSUE, DR_WAIT, DR_DONE} dresp_state_t;

  // Request fields that must survive past the accept cycle (read alignment, FSM path)
  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic [1:0] off;
  } dreq_t;

endpackage

// File: rtl/dbus_lane.sv
// Byte-lane steering for a sub-word access: alignment check, byte strobes,
// lane-replicated write data. Purely combinational; also used by the refill path.
module dbus_lane
  import dbus_sram_resp_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] data,
  output logic        mis,
  output logic [3:0]  wen,
  output logic [31:0] wdata
);

  // Decode size/offset into strobes and replicate the low bytes across all lanes
  always_comb begin
    mis   = 1'b0;
    wen   = 4'b0000;
    wdata = data;
    case (size)
      SZ_BYTE: begin
        wen   = 4'b0001 << offset;
        wdata = {4{data[7:0]}};
      end
      SZ_HALF: begin
        mis   = offset[0];
        wen   = offset[1] ? 4'b1100 : 4'b0011;
        wdata = {2{data[15:0]}};
      end
      SZ_WORD: begin
        mis = |offset;
        wen = 4'b1111;
      end
      default: mis = 1'b1;
    endcase
  end

endmodule

// File: rtl/dbus_sram_resp.sv
// Data-bus responder: accepts one MEM-stage access, drives a fixed-latency
// single-port SRAM, holds the pipeline until done, returns right-aligned load data.
module dbus_sram_resp
  import dbus_sram_resp_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dbus_en,
  input  logic        dbus_we,
  input  logic [1:0]  dbus_size,
  input  logic [31:0] dbus_addr,
  input  logic [31:0] dbus_data,
  output logic        dbus_stall,
  output logic [31:0] dbus_rdata,
  output logic        dbus_adel,
  output logic        dbus_ades,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

  dresp_state_t state, state_nxt;
  logic [2:0]   cnt;
  dreq_t        req_q;
  logic         mis, is_idle, accept;
  logic [3:0]   lane_wen;
  logic [31:0]  lane_wdata, rd_shift, rd_aligned;

  dbus_lane u_lane (
    .size  (dbus_size),
    .offset(dbus_addr[1:0]),
    .data  (dbus_data),
    .mis   (mis),
    .wen   (lane_wen),
    .wdata (lane_wdata)
  );

  // Only IDLE looks at the bus; errors are flagged there without touching the SRAM
  assign is_idle   = (state == DR_IDLE);
  assign accept    = is_idle & dbus_en & ~mis;
  assign dbus_adel = is_idle & dbus_en & ~dbus_we & mis;
  assign dbus_ades = is_idle & dbus_en &  dbus_we & mis;

  // Next state and stall; stall covers the accept cycle through the capture cycle
  always_comb begin
    state_nxt  = state;
    dbus_stall = 1'b0;
    case (state)
      DR_IDLE: if (accept) begin
        state_nxt  = DR_ISSUE;
        dbus_stall = 1'b1;
      end
      DR_ISSUE: begin
        dbus_stall = 1'b1;
        state_nxt  = req_q.we ? DR_DONE : DR_WAIT;
      end
      DR_WAIT: begin
        dbus_stall = 1'b1;
        if (cnt == 3'd0) state_nxt = DR_DONE;
      end
      default: state_nxt = DR_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DR_IDLE;
    else        state <= state_nxt;
  end

  // Read-latency countdown, armed as the SRAM strobe goes out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 cnt <= 3'd0;
    else if (state == DR_ISSUE)                 cnt <= CNT_INIT;
    else if (state == DR_WAIT && cnt != 3'd0)   cnt <= cnt - 3'd1;
  end

  // Latch the request so bus changes while busy are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      req_q <= '0;
    else if (accept) req_q <= '{we: dbus_we, size: dbus_size, off: dbus_addr[1:0]};
  end

  // SRAM port registers; strobe is a single-cycle pulse, byte enables only for stores
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_en    <= 1'b0;
      sram_wen   <= 4'b0000;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      sram_en  <= accept;
      sram_wen <= (accept && dbus_we) ? lane_wen : 4'b0000;
      if (accept) begin
        sram_addr  <= {dbus_addr[31:2], 2'b00};
        sram_wdata <= lane_wdata;
      end
    end
  end

  // Right-align the raw word by the latched offset, then zero above the access size
  always_comb begin
    rd_shift   = sram_rdata >> {req_q.off, 3'b000};
    rd_aligned = rd_shift;
    case (req_q.size)
      SZ_BYTE: rd_aligned = {24'h0, rd_shift[7:0]};
      SZ_HALF: rd_aligned = {16'h0, rd_shift[15:0]};
      default: rd_aligned = rd_shift;
    endcase
  end

  // Load result register, captured in the last WAIT cycle and held until the next load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               dbus_rdata <= '0;
    else if (state == DR_WAIT && cnt == 3'd0) dbus_rdata <= rd_aligned;
  end

endmodule

// File: tb/tb_dbus_sram_resp.sv
// Bench: two responders (LATENCY 1 and 4), each with its own SRAM model;
// expected values come from a byte-level reference memory.
module tb_dbus_sram_resp;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        en, we, stall, adel, ades, sram_en;
  logic [1:0][1:0]   size;
  logic [1:0][3:0]   sram_wen;
  logic [1:0][31:0]  addr, data, rdata, sram_addr, sram_wdata, sram_rdata;

  logic [31:0] mem  [2][256];
  logic [31:0] refm [2][256];
  logic [31:0] pipe [2][8];
  logic [31:0] last_rd [2];
  int cyc = 0;
  int passes = 0;
  int total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dbus_sram_resp #(.LATENCY(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .dbus_en(en[0]), .dbus_we(we[0]), .dbus_size(size[0]),
    .dbus_addr(addr[0]), .dbus_data(data[0]), .dbus_stall(stall[0]), .dbus_rdata(rdata[0]),
    .dbus_adel(adel[0]), .dbus_ades(ades[0]), .sram_en(sram_en[0]), .sram_wen(sram_wen[0]),
    .sram_addr(sram_addr[0]), .sram_wdata(sram_wdata[0]), .sram_rdata(sram_rdata[0]));

  dbus_sram_resp #(.LATENCY(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .dbus_en(en[1]), .dbus_we(we[1]), .dbus_size(size[1]),
    .dbus_addr(addr[1]), .dbus_data(data[1]), .dbus_stall(stall[1]), .dbus_rdata(rdata[1]),
    .dbus_adel(adel[1]), .dbus_ades(ades[1]), .sram_en(sram_en[1]), .sram_wen(sram_wen[1]),
    .sram_addr(sram_addr[1]), .sram_wdata(sram_wdata[1]), .sram_rdata(sram_rdata[1]));

  // SRAM models: writes by byte enable, reads delayed through a pipe, junk otherwise
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 7; i > 0; i--) pipe[d][i] <= pipe[d][i-1];
      pipe[d][0] <= (sram_en[d] && sram_wen[d] == 4'b0) ? mem[d][sram_addr[d][9:2]] : $urandom;
      if (sram_en[d])
        for (int b = 0; b < 4; b++)
          if (sram_wen[d][b]) mem[d][sram_addr[d][9:2]][8*b +: 8] <= sram_wdata[d][8*b +: 8];
    end
  end
  assign sram_rdata[0] = pipe[0][0];
  assign sram_rdata[1] = pipe[1][3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic idle(input int d);
    @(negedge clk);
    en[d] = 1'b0;
    #1;
    chk("idle_stall", 32'(stall[d]), 32'd0);
    chk("idle_sram_en", 32'(sram_en[d]), 32'd0);
    chk("rdata_hold", rdata[d], last_rd[d]);
  endtask

  // One access from the core's point of view; returns the cycle it was presented
  task automatic access(input int d, input logic w, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] dt, output int acc_cyc);
    int L = (d == 0) ? 1 : 4;
    int nb, k;
    logic m;
    logic [1:0] o;
    logic [3:0] ew;
    logic [31:0] ewd, erd, msk;
    o  = a[1:0];
    m  = (sz == 2'd3) || (sz == 2'd1 && o[0]) || (sz == 2'd2 && o != 2'd0);
    nb = 1 << sz;
    ew = 4'b0;
    erd = 32'h0;
    for (int i = 0; i < nb && i < 4; i++) ew[int'(o) + i] = 1'b1;
    for (int j = 0; j < 4; j++) ewd[8*j +: 8] = dt[8*(j % nb) +: 8];
    @(negedge clk);
    en[d] = 1'b1; we[d] = w; size[d] = sz; addr[d] = a; data[d] = dt;
    #1;
    acc_cyc = cyc;
    chk("adel", 32'(adel[d]), 32'(!w && m));
    chk("ades", 32'(ades[d]), 32'(w && m));
    chk("stall_accept", 32'(stall[d]), 32'(!m));
    chk("sram_en_accept", 32'(sram_en[d]), 32'd0);
    if (m) begin
      @(negedge clk);
      en[d] = 1'b0;
      #1;
      chk("mis_sram_en", 32'(sram_en[d]), 32'd0);
      chk("mis_stall", 32'(stall[d]), 32'd0);
      return;
    end
    if (w) begin
      for (int i = 0; i < nb; i++) refm[d][a[9:2]][8*(int'(o) + i) +: 8] = dt[8*i +: 8];
    end else begin
      msk = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*nb)) - 32'h1);
      erd = (refm[d][a[9:2]] >> (8*int'(o))) & msk;
    end
    k = 1;
    forever begin
      @(negedge clk);
      #1;
      if (k == 1) begin
        chk("issue_sram_en", 32'(sram_en[d]), 32'd1);
        chk("sram_addr", sram_addr[d], {a[31:2], 2'b00});
        chk("sram_wen", 32'(sram_wen[d]), w ? 32'(ew) : 32'd0);
        if (w) chk("sram_wdata", sram_wdata[d], ewd);
      end else begin
        chk("sram_en_pulse", 32'(sram_en[d]), 32'd0);
      end
      if (!stall[d]) break;
      // bus is free to wander while the access is in flight
      we[d] = 1'($urandom); size[d] = 2'($urandom); addr[d] = $urandom; data[d] = $urandom;
      k++;
      if (k > 20) begin
        chk("stall_timeout", 32'(k), 32'(w ? 2 : L + 2));
        break;
      end
    end
    we[d] = w; size[d] = sz; addr[d] = a; data[d] = dt;
    chk("stall_window", 32'(k), 32'(w ? 2 : L + 2));
    if (!w) begin
      chk("rdata", rdata[d], erd);
      last_rd[d] = erd;
    end
  endtask

  initial begin
    int c1, c2;
    rst_n = 1'b0;
    en = '0; we = '0; size = '0; addr = '0; data = '0;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++) begin
        mem[d][i]  = $urandom;
        refm[d][i] = mem[d][i];
      end
    for (int i = 0; i < 8; i++) begin pipe[0][i] = 32'h0; pipe[1][i] = 32'h0; end
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_stall", 32'(stall[d]), 32'd0);
      chk("rst_rdata", rdata[d], 32'd0);
      chk("rst_sram_en", 32'(sram_en[d]), 32'd0);
      chk("rst_sram_wen", 32'(sram_wen[d]), 32'd0);
      chk("rst_sram_addr", sram_addr[d], 32'd0);
      chk("rst_sram_wdata", sram_wdata[d], 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed: word load, byte store, half load, misaligned store/load
    mem[0][8'h40] = 32'hDEAD_BEEF; refm[0][8'h40] = 32'hDEAD_BEEF;
    access(0, 1'b0, 2'd2, 32'h100, 32'h0, c1);
    chk("word_load_rdata", rdata[0], 32'hDEAD_BEEF);
    idle(0);
    access(0, 1'b1, 2'd0, 32'h203, 32'h0000_00A5, c1);
    idle(0);
    mem[0][8'h40] = 32'h1234_5678; refm[0][8'h40] = 32'h1234_5678;
    access(0, 1'b0, 2'd1, 32'h102, 32'h0, c1);
    chk("half_load_rdata", rdata[0], 32'h0000_1234);
    idle(0);
    access(0, 1'b1, 2'd2, 32'h101, 32'h1111_2222, c1);
    access(0, 1'b0, 2'd1, 32'h103, 32'h0, c1);
    idle(0);

    // Back-to-back loads on the LATENCY=4 responder
    access(1, 1'b0, 2'd2, 32'h100, 32'h0, c1);
    access(1, 1'b0, 2'd2, 32'h204, 32'h0, c2);
    chk("b2b_spacing", 32'(c2 - c1), 32'd7);
    idle(1);

    // Reset in the middle of a WAIT
    access(1, 1'b0, 2'd2, 32'h0F0, 32'h0, c1);
    idle(1);
    @(negedge clk);
    en[1] = 1'b1; we[1] = 1'b0; size[1] = 2'd2; addr[1] = 32'h100;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    en[1] = 1'b0;
    #1;
    chk("rst_mid_sram_en", 32'(sram_en[1]), 32'd0);
    chk("rst_mid_stall", 32'(stall[1]), 32'd0);
    chk("rst_mid_rdata", rdata[1], 32'd0);
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    access(1, 1'b0, 2'd0, 32'h101, 32'h0, c1);
    idle(1);

    // Randomized traffic on both responders
    for (int n = 0; n < 60; n++) begin
      int d = n % 2;
      access(d, 1'($urandom), 2'($urandom), 32'($urandom_range(0, 1023)), $urandom, c1);
      if ($urandom_range(0, 1) == 1) idle(d);
      else if (!en[d] && d == 0) idle(d);
    end
    idle(0);
    idle(1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
